// File: rtl/crc_serial_engine.sv
// crc_serial_engine: bit-serial CRC engine with GENERATE and CHECK modes.
// GENERATE absorbs a serial frame and then shifts the CRC out LSB-first.
// CHECK absorbs a frame plus its appended CRC and reports whether the
// residue is zero.
// Optional build macro: CRC_PAR_OUT_EN adds a parallel snapshot of the
// final LFSR value (CRC_PAR) with a one-cycle strobe (PAR_VALID).
module crc_serial_engine #(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLY      = 8'h44,
  parameter logic [CRC_WIDTH-1:0] SEED      = 8'hD8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ACTIVE,
  input  logic                 DATA,
  input  logic                 MODE,
  output logic                 CRC,
  output logic                 Valid,
  output logic                 BUSY,
  output logic                 CRC_OK
`ifdef CRC_PAR_OUT_EN
  ,
  output logic [CRC_WIDTH-1:0] CRC_PAR,
  output logic                 PAR_VALID
`endif
);

  localparam int CNT_W = $clog2(CRC_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CRC_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, OUT, RESULT} state_t;

  state_t               state, state_nxt;
  logic [CRC_WIDTH-1:0] lfsr, lfsr_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 mode, mode_nxt;
  logic                 crc_nxt, vld_nxt, ok_nxt;

  // One Galois absorb step: feedback enters the top bit and the tapped bits.
  function automatic logic [CRC_WIDTH-1:0] absorb(input logic [CRC_WIDTH-1:0] l,
                                                  input logic d);
    logic                 fb;
    logic [CRC_WIDTH-1:0] r;
    fb = d ^ l[0];
    r  = {1'b0, l[CRC_WIDTH-1:1]} ^ (POLY & {CRC_WIDTH{fb}});
    r[CRC_WIDTH-1] = fb;
    return r;
  endfunction

  assign BUSY = (state == OUT);

  // Next-state, next-LFSR and registered-output values.
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    crc_nxt   = 1'b0;
    vld_nxt   = 1'b0;
    ok_nxt    = CRC_OK;
    case (state)
      IDLE: begin
        if (ACTIVE) begin
          mode_nxt  = MODE;
          lfsr_nxt  = absorb(SEED, DATA);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ACTIVE) begin
          lfsr_nxt = absorb(lfsr, DATA);
        end else if (mode) begin
          state_nxt = RESULT;
        end else begin
          cnt_nxt   = '0;
          state_nxt = OUT;
        end
      end
      OUT: begin
        crc_nxt  = lfsr[0];
        vld_nxt  = 1'b1;
        lfsr_nxt = {1'b0, lfsr[CRC_WIDTH-1:1]};
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST) begin
          lfsr_nxt  = SEED;
          state_nxt = IDLE;
        end
      end
      RESULT: begin
        vld_nxt   = 1'b1;
        ok_nxt    = (lfsr == '0);
        lfsr_nxt  = SEED;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, LFSR, counter and serial outputs; reset discards any partial frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      lfsr   <= SEED;
      cnt    <= '0;
      mode   <= 1'b0;
      CRC    <= 1'b0;
      Valid  <= 1'b0;
      CRC_OK <= 1'b0;
    end else begin
      state  <= state_nxt;
      lfsr   <= lfsr_nxt;
      cnt    <= cnt_nxt;
      mode   <= mode_nxt;
      CRC    <= crc_nxt;
      Valid  <= vld_nxt;
      CRC_OK <= ok_nxt;
    end
  end

`ifdef CRC_PAR_OUT_EN
  logic frame_end;
  assign frame_end = (state == SHIFT) && !ACTIVE;

  // Snapshot the final LFSR value when a frame ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CRC_PAR   <= '0;
      PAR_VALID <= 1'b0;
    end else begin
      PAR_VALID <= frame_end;
      if (frame_end) CRC_PAR <= lfsr;
    end
  end
`endif

endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: table-driven and randomized bench for crc_serial_engine.
module tb_crc_serial_engine;

  localparam int          W    = 8;
  localparam logic [7:0]  POLY = 8'h44;
  localparam logic [7:0]  SEED = 8'hD8;
  // Reflected-CRC mask: the top LFSR bit always receives the feedback.
  localparam int unsigned MASK = 32'(POLY) | (32'd1 << (W - 1));

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic ACTIVE = 1'b0;
  logic DATA = 1'b0;
  logic MODE = 1'b0;
  logic CRC, Valid, BUSY, CRC_OK;
`ifdef CRC_PAR_OUT_EN
  logic [W-1:0] CRC_PAR;
  logic         PAR_VALID;
`endif

  always #5 CLK = ~CLK;

  crc_serial_engine #(.CRC_WIDTH(W), .POLY(POLY), .SEED(SEED)) dut (
    .CLK(CLK), .RST(RST), .ACTIVE(ACTIVE), .DATA(DATA), .MODE(MODE),
    .CRC(CRC), .Valid(Valid), .BUSY(BUSY), .CRC_OK(CRC_OK)
`ifdef CRC_PAR_OUT_EN
    , .CRC_PAR(CRC_PAR), .PAR_VALID(PAR_VALID)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] bits;
    int          len;
    logic        mode;
    logic [7:0]  exp_crc;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Standard software reflected CRC over a bit list, LSB-first.
  function automatic logic [7:0] model_crc(input logic [63:0] bits, input int len);
    int unsigned c;
    c = 32'(SEED);
    for (int i = 0; i < len; i++) begin
      c = c ^ 32'(bits[i]);
      if (c[0]) c = (c >> 1) ^ MASK;
      else      c = c >> 1;
    end
    return c[7:0];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a frame; MODE is flipped after the first bit to prove it is latched.
  task automatic drive_frame(input logic [63:0] bits, input int len, input logic mode);
    for (int i = 0; i < len; i++) begin
      ACTIVE = 1'b1;
      DATA   = bits[i];
      MODE   = (i == 0) ? mode : ~mode;
      tick();
    end
    ACTIVE = 1'b0;
    DATA   = 1'b0;
    MODE   = 1'b0;
  endtask

  task automatic collect_gen(input bit poke, output logic [7:0] crc, output int first,
                             output int last, output int busy_n, output bit tmo);
    int n;
    n = 0; crc = '0; first = -1; last = -1; busy_n = 0; tmo = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (BUSY) busy_n++;
      if (Valid) begin
        if (n == 0) first = cyc;
        crc[n[2:0]] = CRC;
        n++;
        last = cyc;
      end
      if (poke) begin
        if (cyc == 2 || cyc == 3) begin
          ACTIVE = 1'b1;
          DATA   = 1'($urandom_range(0, 1));
        end else begin
          ACTIVE = 1'b0;
        end
      end
      if (n == W) begin
        tmo = 1'b0;
        break;
      end
    end
    ACTIVE = 1'b0;
  endtask

  task automatic collect_chk(output logic ok, output int first, output int pulse,
                             output bit busy_seen, output bit tmo);
    ok = 1'b0; first = -1; pulse = 0; busy_seen = 1'b0; tmo = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (BUSY) busy_seen = 1'b1;
      if (Valid) begin
        ok = CRC_OK;
        first = cyc;
        tmo = 1'b0;
        break;
      end
    end
    if (!tmo) begin
      pulse = 1;
      tick();
      if (Valid) pulse++;
    end
  endtask

  task automatic run_gen(input string tag, input logic [63:0] bits, input int len,
                         input logic [7:0] exp, input bit poke);
    logic [7:0] crc;
    int first, last, busy_n;
    bit tmo;
    drive_frame(bits, len, 1'b0);
    collect_gen(poke, crc, first, last, busy_n, tmo);
    check({tag, "_timeout"}, 64'(tmo), 64'd0);
    check({tag, "_crc"}, 64'(crc), 64'(exp));
    check({tag, "_first_valid"}, 64'(first), 64'd2);
    check({tag, "_valid_run"}, 64'(last - first), 64'(W - 1));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
`ifdef CRC_PAR_OUT_EN
    check({tag, "_crc_par"}, 64'(CRC_PAR), 64'(exp));
`endif
  endtask

  task automatic run_chk(input string tag, input logic [63:0] bits, input int len,
                         input logic exp_ok);
    logic ok;
    int first, pulse;
    bit busy_seen, tmo;
    drive_frame(bits, len, 1'b1);
    collect_chk(ok, first, pulse, busy_seen, tmo);
    check({tag, "_timeout"}, 64'(tmo), 64'd0);
    check({tag, "_crc_ok"}, 64'(ok), 64'(exp_ok));
    check({tag, "_first_valid"}, 64'(first), 64'd2);
    check({tag, "_pulse_len"}, 64'(pulse), 64'd1);
    check({tag, "_busy"}, 64'(busy_seen), 64'd0);
    check({tag, "_ok_hold"}, 64'(CRC_OK), 64'(exp_ok));
  endtask

  initial begin
    logic [63:0] bits;
    logic [7:0]  c;
    int          len, n;
    logic        mode;

    // Hand-derived vectors: A5 from seed D8 with mask C4 gives 7D.
    vecs[0] = '{64'hA5,   8,  1'b0, 8'h7D, 1'b0};
    vecs[1] = '{64'h7DA5, 16, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{64'h7DAD, 16, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{64'h1,    1,  1'b0, 8'hA8, 1'b0};
    vecs[4] = '{64'h0,    1,  1'b0, 8'h6C, 1'b0};
    vecs[5] = '{64'h0,    1,  1'b1, 8'h00, 1'b0};

    RST = 1'b0;
    repeat (3) tick();
    check("rst_crc", 64'(CRC), 64'd0);
    check("rst_valid", 64'(Valid), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_crc_ok", 64'(CRC_OK), 64'd0);
    check("rst_lfsr", 64'(dut.lfsr), 64'(SEED));
    RST = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].mode == 1'b0) begin
        run_gen($sformatf("vec%0d", i), vecs[i].bits, vecs[i].len, vecs[i].exp_crc, 1'b0);
        tick();
        check($sformatf("vec%0d_valid_drop", i), 64'(Valid), 64'd0);
      end else begin
        run_chk($sformatf("vec%0d", i), vecs[i].bits, vecs[i].len, vecs[i].exp_ok);
      end
    end

    // ACTIVE pulsed during OUT is ignored; a frame on the first IDLE cycle starts from SEED.
    run_gen("b2b_a", 64'hA5, 8, 8'h7D, 1'b1);
    run_gen("b2b_b", 64'h3C, 8, model_crc(64'h3C, 8), 1'b0);
    tick();

    // Reset after three CRC bits have been output.
    drive_frame(64'hA5, 8, 1'b0);
    n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (Valid) n++;
      if (n == 3) break;
    end
    check("midout_bits_seen", 64'(n), 64'd3);
    RST = 1'b0;
    #1;
    check("midout_rst_valid", 64'(Valid), 64'd0);
    check("midout_rst_busy", 64'(BUSY), 64'd0);
    check("midout_rst_crc", 64'(CRC), 64'd0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    run_gen("post_rst", 64'h5A, 8, model_crc(64'h5A, 8), 1'b0);
    tick();

    // Randomized frames against the software CRC.
    for (int k = 0; k < 20; k++) begin
      len  = $urandom_range(1, 24);
      bits = {32'($urandom), 32'($urandom)};
      for (int b = len; b < 64; b++) bits[b] = 1'b0;
      mode = 1'($urandom_range(0, 1));
      if (mode == 1'b0) begin
        run_gen($sformatf("rnd%0d_gen", k), bits, len, model_crc(bits, len), 1'b0);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          c = model_crc(bits, len);
          for (int b = 0; b < W; b++) bits[len + b] = c[b];
          len = len + W;
        end
        run_chk($sformatf("rnd%0d_chk", k), bits, len, model_crc(bits, len) == 8'h00);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
